// File: rtl/imem_loader_if.sv
// imem_loader_if: groups the loader's byte-stream handshake, the instruction
// RAM write port and the status lines into a single bundle.
//
// Signals:
//   i_rx_data / i_rx_valid / o_rx_ready : byte stream from the UART receiver
//   o_mem_addr / o_mem_data / o_mem_we  : instruction RAM write port
//   o_cpu_halt                          : stalls PC and IF/ID while loading
//   o_load_done / o_load_err            : status reported to the debug unit
//
// Modports:
//   master : the loader (consumes bytes, drives RAM and status lines)
//   slave  : the surrounding system (UART side, RAM, CPU, debug unit)
interface imem_loader_if #(
  parameter int NB_BITS   = 32,
  parameter int RAM_DEPTH = 10
);
  logic [7:0]           i_rx_data;
  logic                 i_rx_valid;
  logic                 o_rx_ready;
  logic [RAM_DEPTH-1:0] o_mem_addr;
  logic [NB_BITS-1:0]   o_mem_data;
  logic                 o_mem_we;
  logic                 o_cpu_halt;
  logic                 o_load_done;
  logic                 o_load_err;

  modport master (
    input  i_rx_data, i_rx_valid,
    output o_rx_ready, o_mem_addr, o_mem_data, o_mem_we,
    output o_cpu_halt, o_load_done, o_load_err
  );

  modport slave (
    output i_rx_data, i_rx_valid,
    input  o_rx_ready, o_mem_addr, o_mem_data, o_mem_we,
    input  o_cpu_halt, o_load_done, o_load_err
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: debug-side writer for the instruction memory.
//
// Receives a framed program image byte by byte, assembles big-endian 32-bit
// words and writes them to sequential instruction RAM word addresses while
// holding the CPU halted.
//
// Frame: START_BYTE, count MSB, count LSB, count x 4 data bytes (MSB first),
//        then one XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
//
// Configuration macro:
//   IMEM_LOADER_CHECKSUM_EN : when defined, a trailing checksum byte is
//                             expected and checked (CHK state exists).
//
// Ports:
//   i_clk : clock, rising edge
//   i_rst : synchronous active-high reset
//   bus   : imem_loader_if.master (byte stream in, RAM write port and
//           halt/done/error status out)
//
// All outputs come from registers or decode of the state register only.
module imem_loader #(
  parameter int         NB_BITS    = 32,
  parameter int         RAM_DEPTH  = 10,
  parameter logic [7:0] START_BYTE = 8'hA5
) (
  input  logic          i_clk,
  input  logic          i_rst,
  imem_loader_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, CNT_HI, CNT_LO, DATA, WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHK,
`endif
    DONE, ERR
  } state_t;

  // Where to go once the last word has been written (or count was zero).
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t AFTER_DATA = CHK;
`else
  localparam state_t AFTER_DATA = DONE;
`endif

  // A full RAM (2^RAM_DEPTH words) is a legal image; anything larger is not.
  localparam logic [16:0] COUNT_LIMIT = 17'd1 << RAM_DEPTH;

  state_t               state_reg, state_next;
  logic [7:0]           cnt_hi_reg, cnt_hi_next;
  logic [16:0]          words_left_reg, words_left_next;
  logic [RAM_DEPTH-1:0] addr_reg, addr_next;
  logic [NB_BITS-1:0]   word_reg, word_next;
  logic [1:0]           byte_cnt_reg, byte_cnt_next;
  logic                 err_reg, err_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]           chk_reg, chk_next;
`endif

  logic        rx_ready;
  logic        accept;
  logic [16:0] count_full;

  assign rx_ready   = (state_reg != WRITE);
  assign accept     = bus.i_rx_valid && rx_ready;
  assign count_full = {1'b0, cnt_hi_reg, bus.i_rx_data};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg      <= IDLE;
      cnt_hi_reg     <= '0;
      words_left_reg <= '0;
      addr_reg       <= '0;
      word_reg       <= '0;
      byte_cnt_reg   <= '0;
      err_reg        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_reg        <= '0;
`endif
    end else begin
      state_reg      <= state_next;
      cnt_hi_reg     <= cnt_hi_next;
      words_left_reg <= words_left_next;
      addr_reg       <= addr_next;
      word_reg       <= word_next;
      byte_cnt_reg   <= byte_cnt_next;
      err_reg        <= err_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_reg        <= chk_next;
`endif
    end
  end

  always_comb begin
    state_next      = state_reg;
    cnt_hi_next     = cnt_hi_reg;
    words_left_next = words_left_reg;
    addr_next       = addr_reg;
    word_next       = word_reg;
    byte_cnt_next   = byte_cnt_reg;
    err_next        = err_reg;
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk_next        = chk_reg;
`endif

    case (state_reg)
      IDLE: begin
        // Non-start bytes are consumed and dropped while idle.
        if (accept && bus.i_rx_data == START_BYTE) begin
          state_next    = CNT_HI;
          err_next      = 1'b0;
          addr_next     = '0;
          byte_cnt_next = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          chk_next      = '0;
`endif
        end
      end
      CNT_HI: begin
        if (accept) begin
          cnt_hi_next = bus.i_rx_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
          chk_next    = chk_reg ^ bus.i_rx_data;
`endif
          state_next  = CNT_LO;
        end
      end
      CNT_LO: begin
        if (accept) begin
          words_left_next = count_full;
`ifdef IMEM_LOADER_CHECKSUM_EN
          chk_next        = chk_reg ^ bus.i_rx_data;
`endif
          if (count_full > COUNT_LIMIT)
            state_next = ERR;
          else if (count_full == '0)
            state_next = AFTER_DATA;
          else
            state_next = DATA;
        end
      end
      DATA: begin
        if (accept) begin
          // First byte of a word ends up in the most significant lane.
          word_next     = {word_reg[NB_BITS-9:0], bus.i_rx_data};
          byte_cnt_next = byte_cnt_reg + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          chk_next      = chk_reg ^ bus.i_rx_data;
`endif
          if (byte_cnt_reg == 2'd3)
            state_next = WRITE;
        end
      end
      WRITE: begin
        words_left_next = words_left_reg - 17'd1;
        if (words_left_reg == 17'd1) begin
          // Address is left on the last word so it never wraps inside a frame.
          state_next = AFTER_DATA;
        end else begin
          state_next = DATA;
          addr_next  = addr_reg + RAM_DEPTH'(1);
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: begin
        if (accept)
          state_next = (bus.i_rx_data == chk_reg) ? DONE : ERR;
      end
`endif
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Error flag is sticky until the next start byte.
    if (state_next == ERR)
      err_next = 1'b1;
  end

  assign bus.o_rx_ready  = rx_ready;
  assign bus.o_mem_we    = (state_reg == WRITE);
  assign bus.o_mem_addr  = addr_reg;
  assign bus.o_mem_data  = word_reg;
  assign bus.o_cpu_halt  = (state_reg != IDLE);
  assign bus.o_load_done = (state_reg == DONE);
  assign bus.o_load_err  = err_reg;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader.
// Builds with or without IMEM_LOADER_CHECKSUM_EN; checksum bytes are only
// sent when the macro is defined.
`ifdef IMEM_LOADER_CHECKSUM_EN
`define SEND_CHK(c) send_byte(c);
`else
`define SEND_CHK(c)
`endif

module tb_imem_loader;
  logic clk;
  logic rst;

  imem_loader_if bus ();

  imem_loader dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Write/done/ready monitor: samples the cycle that ends at each rising edge.
  int          wr_n = 0;
  int          done_n = 0;
  int          rdy_low_n = 0;
  int          rdy_bad_n = 0;
  logic [9:0]  wr_addr [16];
  logic [31:0] wr_data [16];
  logic [9:0]  last_addr = '0;
  logic [31:0] last_data = '0;

  always @(posedge clk) begin
    if (bus.o_mem_we) begin
      if (wr_n < 16) begin
        wr_addr[wr_n] <= bus.o_mem_addr;
        wr_data[wr_n] <= bus.o_mem_data;
      end
      last_addr <= bus.o_mem_addr;
      last_data <= bus.o_mem_data;
      wr_n      <= wr_n + 1;
    end
    if (bus.o_load_done) done_n <= done_n + 1;
    if (!bus.o_rx_ready) begin
      rdy_low_n <= rdy_low_n + 1;
      if (!bus.o_mem_we) rdy_bad_n <= rdy_bad_n + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.i_rx_data  = b;
    bus.i_rx_valid = 1'b1;
    while (!bus.o_rx_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("send_byte_ready_timeout", 32'(bus.o_rx_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.i_rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  // Wait (bounded) until the loader reaches DONE or ERR.
  task automatic wait_end(input string tag);
    int n;
    n = 0;
    while (!(bus.o_load_done || bus.o_load_err) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(bus.o_load_done || bus.o_load_err), 32'd1);
  endtask

  task automatic clear_mon();
    wr_n      = 0;
    done_n    = 0;
    rdy_low_n = 0;
    rdy_bad_n = 0;
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] big_chk;
`endif

  initial begin
    rst            = 1'b1;
    bus.i_rx_valid = 1'b0;
    bus.i_rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_ready", 32'(bus.o_rx_ready), 32'd1);
    check("rst_we",    32'(bus.o_mem_we), 32'd0);
    check("rst_addr",  32'(bus.o_mem_addr), 32'd0);
    check("rst_data",  bus.o_mem_data, 32'd0);
    check("rst_halt",  32'(bus.o_cpu_halt), 32'd0);
    check("rst_done",  32'(bus.o_load_done), 32'd0);
    check("rst_err",   32'(bus.o_load_err), 32'd0);

    // Single-word frame
    clear_mon();
    send_byte(8'hA5);
    check("t1_halt_rise", 32'(bus.o_cpu_halt), 32'd1);
    send_byte(8'h00);
    send_byte(8'h01);
    send_word(32'h20080005);
    check("t1_we",    32'(bus.o_mem_we), 32'd1);
    check("t1_addr",  32'(bus.o_mem_addr), 32'd0);
    check("t1_data",  bus.o_mem_data, 32'h20080005);
    check("t1_ready_low", 32'(bus.o_rx_ready), 32'd0);
    `SEND_CHK(8'h2C)
    wait_end("t1_end");
    check("t1_done_pulse", 32'(bus.o_load_done), 32'd1);
    check("t1_halt_in_done", 32'(bus.o_cpu_halt), 32'd1);
    @(negedge clk);
    check("t1_done_fall", 32'(bus.o_load_done), 32'd0);
    check("t1_halt_fall", 32'(bus.o_cpu_halt), 32'd0);
    check("t1_err", 32'(bus.o_load_err), 32'd0);
    check("t1_wr_n", 32'(wr_n), 32'd1);
    check("t1_done_n", 32'(done_n), 32'd1);
    $display("t1 single word frame: writes=%0d done=%0d", wr_n, done_n);

    // Three-word frame
    clear_mon();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h03);
    send_word(32'h11111111);
    send_word(32'h22222222);
    send_word(32'h33333333);
    `SEND_CHK(8'h03)
    wait_end("t2_end");
    @(negedge clk);
    check("t2_wr_n",   32'(wr_n), 32'd3);
    check("t2_addr0",  32'(wr_addr[0]), 32'd0);
    check("t2_addr1",  32'(wr_addr[1]), 32'd1);
    check("t2_addr2",  32'(wr_addr[2]), 32'd2);
    check("t2_data0",  wr_data[0], 32'h11111111);
    check("t2_data1",  wr_data[1], 32'h22222222);
    check("t2_data2",  wr_data[2], 32'h33333333);
    check("t2_rdy_low", 32'(rdy_low_n), 32'd3);
    check("t2_rdy_bad", 32'(rdy_bad_n), 32'd0);
    check("t2_done_n", 32'(done_n), 32'd1);
    check("t2_err",    32'(bus.o_load_err), 32'd0);
    $display("t2 three word frame: writes=%0d ready_low=%0d done=%0d", wr_n, rdy_low_n, done_n);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Wrong checksum: the write still happens, error instead of done
    clear_mon();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h01);
    send_word(32'hDEADBEEF);
    send_byte(8'h00);
    wait_end("t3_end");
    @(negedge clk);
    check("t3_err",    32'(bus.o_load_err), 32'd1);
    check("t3_done_n", 32'(done_n), 32'd0);
    check("t3_wr_n",   32'(wr_n), 32'd1);
    check("t3_data",   wr_data[0], 32'hDEADBEEF);
    send_byte(8'hA5);
    check("t3_err_clear", 32'(bus.o_load_err), 32'd0);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    wait_end("t3b_end");
    @(negedge clk);
    $display("t3 bad checksum frame: err flagged then cleared, done=%0d", done_n);
`endif

    // Count of zero: no writes, done
    clear_mon();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h00);
    `SEND_CHK(8'h00)
    wait_end("t0_end");
    @(negedge clk);
    check("t0_wr_n",   32'(wr_n), 32'd0);
    check("t0_done_n", 32'(done_n), 32'd1);
    check("t0_halt",   32'(bus.o_cpu_halt), 32'd0);
    $display("t0 zero count frame: writes=%0d done=%0d", wr_n, done_n);

    // Count overflow 0x0401 > 1024
    clear_mon();
    send_byte(8'hA5);
    send_byte(8'h04);
    send_byte(8'h01);
    check("t4_err",        32'(bus.o_load_err), 32'd1);
    check("t4_halt_in_err", 32'(bus.o_cpu_halt), 32'd1);
    @(negedge clk);
    check("t4_halt_fall", 32'(bus.o_cpu_halt), 32'd0);
    check("t4_err_sticky", 32'(bus.o_load_err), 32'd1);
    @(negedge clk);
    check("t4_wr_n",   32'(wr_n), 32'd0);
    check("t4_done_n", 32'(done_n), 32'd0);
    $display("t4 count overflow: err=%0d writes=%0d", bus.o_load_err, wr_n);

    // Garbage in idle, then a frame whose data contains the start value
    clear_mon();
    send_byte(8'h00);
    check("t5_halt_g0", 32'(bus.o_cpu_halt), 32'd0);
    send_byte(8'hFF);
    check("t5_halt_g1", 32'(bus.o_cpu_halt), 32'd0);
    send_byte(8'h13);
    check("t5_halt_g2", 32'(bus.o_cpu_halt), 32'd0);
    check("t5_err_kept", 32'(bus.o_load_err), 32'd1);
    send_byte(8'hA5);
    check("t5_err_clear", 32'(bus.o_load_err), 32'd0);
    send_byte(8'h00);
    send_byte(8'h01);
    send_word(32'hA5123456);
    `SEND_CHK(8'hD4)
    wait_end("t5_end");
    @(negedge clk);
    check("t5_wr_n",   32'(wr_n), 32'd1);
    check("t5_addr",   32'(wr_addr[0]), 32'd0);
    check("t5_data",   wr_data[0], 32'hA5123456);
    check("t5_done_n", 32'(done_n), 32'd1);
    check("t5_err",    32'(bus.o_load_err), 32'd0);
    $display("t5 garbage then frame: writes=%0d data=%h", wr_n, wr_data[0]);

    // Full RAM: 1024 words, last address 1023
    clear_mon();
`ifdef IMEM_LOADER_CHECKSUM_EN
    big_chk = 8'h04;
`endif
    send_byte(8'hA5);
    send_byte(8'h04);
    send_byte(8'h00);
    for (int i = 0; i < 1024; i++) begin
      logic [31:0] w;
      w = 32'(i) ^ 32'hC0DE0000;
`ifdef IMEM_LOADER_CHECKSUM_EN
      big_chk = big_chk ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
`endif
      send_word(w);
    end
    `SEND_CHK(big_chk)
    wait_end("tf_end");
    @(negedge clk);
    check("tf_wr_n",      32'(wr_n), 32'd1024);
    check("tf_last_addr", 32'(last_addr), 32'd1023);
    check("tf_last_data", last_data, 32'hC0DE03FF);
    check("tf_addr3",     32'(wr_addr[3]), 32'd3);
    check("tf_done_n",    32'(done_n), 32'd1);
    check("tf_err",       32'(bus.o_load_err), 32'd0);
    $display("tf full ram frame: writes=%0d last_addr=%0d", wr_n, last_addr);

    // Reset in the middle of a word
    clear_mon();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    rst = 1'b1;
    @(negedge clk);
    check("t6_ready", 32'(bus.o_rx_ready), 32'd1);
    check("t6_we",    32'(bus.o_mem_we), 32'd0);
    check("t6_addr",  32'(bus.o_mem_addr), 32'd0);
    check("t6_data",  bus.o_mem_data, 32'd0);
    check("t6_halt",  32'(bus.o_cpu_halt), 32'd0);
    check("t6_done",  32'(bus.o_load_done), 32'd0);
    check("t6_err",   32'(bus.o_load_err), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_wr_n",   32'(wr_n), 32'd0);
    check("t6_done_n", 32'(done_n), 32'd0);
    check("t6_halt_after", 32'(bus.o_cpu_halt), 32'd0);
    $display("t6 reset mid frame: writes=%0d done=%0d", wr_n, done_n);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
